// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the APB request arbiter.
//   arb_state_t : sequencer state (IDLE / SETUP / ACCESS)
//   PH_*        : APB phase encodings as {psel, penable}
//   phase_of()  : maps a sequencer state to its APB phase encoding
// -----------------------------------------------------------------------------
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  // APB phase encodings, bit 1 = psel, bit 0 = penable
  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_SETUP  = 2'b10;
  localparam logic [1:0] PH_ACCESS = 2'b11;

  function automatic logic [1:0] phase_of(input arb_state_t s);
    logic [1:0] ph;
    ph = PH_IDLE;
    case (s)
      SETUP:   ph = PH_SETUP;
      ACCESS:  ph = PH_ACCESS;
      default: ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req upward from ptr, wrapping
// at NREQ, and returns the first set bit.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  IDW   search start position (0..NREQ-1)
//   grant   out NREQ  one-hot winner (all zero if no request)
//   id      out IDW   binary index of the winner
//   any_req out 1     at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any_req
);

  int             idx;
  logic [IDW-1:0] sel;

  always_comb begin
    grant   = '0;
    id      = '0;
    any_req = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // candidate position k steps above ptr, wrapped into 0..NREQ-1
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = idx[IDW-1:0];
      if (!any_req && req[sel]) begin
        any_req    = 1'b1;
        grant[sel] = 1'b1;
        id         = sel;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
// Shares one APB master port among NREQ requesters. A round-robin pick in
// IDLE latches the winner's command, the FSM runs SETUP then ACCESS, and the
// winner gets a one-cycle req_ack when pready completes the transfer.
// Optional feature macro: APB_ARB_TIMEOUT_EN -- aborts an ACCESS phase after
// TIMEOUT wait cycles and completes it with req_err=1.
// Ports:
//   clk, rst (async, active high)
//   req_valid/req_wr [NREQ], req_addr [NREQ*AW], req_wdata [NREQ*DW]
//   req_ack [NREQ] one-hot, req_err, rsp_rdata [DW]
//   psel, penable, pwrite, paddr [AW], pwdata [DW], prdata [DW], pready
// -----------------------------------------------------------------------------
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic               req_err,
  output logic [DW-1:0]      rsp_rdata,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready
);

  localparam int             IDW     = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic           wr_q, wr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  pick_id;
  logic            any_req;
  logic            tmo;
  logic            done;
  logic [1:0]      phase;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .id      (pick_id),
    .any_req (any_req)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts completed wait cycles, so the TIMEOUT-th ACCESS cycle
  // without pready sees cnt_q == TIMEOUT-1 and aborts in that cycle.
  assign tmo = (state_q == ACCESS) && !pready && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign req_err = tmo;
`else
  assign tmo     = 1'b0;
  assign req_err = 1'b0;
`endif

  // Completion: normal pready wins over a simultaneous timeout.
  assign done = (state_q == ACCESS) && (pready || tmo);

  always_comb begin
    req_ack = '0;
    if (done) req_ack[id_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SETUP;
          id_d    = pick_id;
          // AND-OR select of the winner's command through the one-hot grant
          for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              wr_d    = req_wr[i];
              addr_d  = req_addr[i*AW +: AW];
              wdata_d = req_wdata[i*DW +: DW];
            end
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          state_d = IDLE;
          ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
          // an aborted read leaves the previous read data in place
          if (pready && !wr_q) rdata_d = prdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign phase     = phase_of(state_q);
  assign psel      = phase[1];
  assign penable   = phase[0];
  assign pwrite    = wr_q;
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule
